lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
Load/store sequencer between the CU execute stage and the MMU. It accepts one RV32I load or store per request and computes the effective byte address. It drives the MMU request bus (address, byte enables, lane-aligned write data, retrieve pulse), waits for mmu_complete, then returns sign- or zero-extended load data to the CU. It detects misaligned and illegal accesses without issuing any MMU transaction.

Parameters:
TIMEOUT_CYCLES, 64, number of WAIT cycles without mmu_complete before a timeout fault (used only with LSU_TIMEOUT_EN).

Ports:
soc_clk  in  1  system clock
soc_rst  in  1  reset, synchronous, active-high
lsu_start  in  1  request strobe from CU, sampled only in IDLE
lsu_is_store  in  1  0 = load, 1 = store
lsu_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
lsu_base  in  32  rs1 value
lsu_offset  in  32  sign-extended immediate
lsu_store_data  in  32  rs2 value
lsu_load_data  out  32  extended load result
lsu_done  out  1  one-cycle completion pulse
lsu_busy  out  1  high in every state except IDLE
lsu_fault  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout; valid with lsu_done
CU_address  out  32  byte address to MMU
CU_bytesel  out  4  byte enables to MMU
CU_dat_in  out  32  lane-aligned write data to MMU
read_or_write  out  1  0 = read, 1 = write
retrieve  out  1  MMU start pulse
CU_dat_out  in  32  word read from MMU
mmu_complete  in  1  MMU completion

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0. Reset mid-operation aborts the access immediately. A late mmu_complete arriving in IDLE is ignored.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: on lsu_start, latch is_store, funct3 and store_data. Compute addr = lsu_base + lsu_offset mod 2^32. Check the request:
  - Illegal: store with funct3 not in {000,001,010}, or load with funct3 in {011,110,111}. Go to DONE with fault 10.
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0. Go to DONE with fault 01.
  - Otherwise go to ISSUE.
  - Checks follow the priority order above.
- ISSUE (exactly 1 cycle): retrieve=1. CU_address=addr (full byte address, not masked). read_or_write=is_store. CU_bytesel and CU_dat_in as below. Go to WAIT, or to DONE if mmu_complete=1 this cycle.
- Byte enables: B/BU gives 4'b0001<<addr[1:0]; H/HU gives 0011 if addr[1]=0, else 1100; W gives 1111.
- Write data: store_data low byte/half/word shifted left by 8*addr[1:0]. Non-enabled lanes are 0.
- WAIT: retrieve=0. CU_address, CU_bytesel, CU_dat_in and read_or_write stay stable until DONE. On mmu_complete go to DONE.
- DONE (exactly 1 cycle): lsu_done=1 and lsu_fault valid.
  - Load data: select the lane of CU_dat_out captured on the complete edge using addr[1:0].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
  - Stores and faults give lsu_load_data=0.
  - Next state is IDLE. lsu_load_data holds until the next lsu_done.
- Latency: with lsu_start at edge N and complete sampled at N+1 (ISSUE), lsu_done is high in cycle N+2. A fault gives lsu_done in cycle N+1 with retrieve never asserted.
- lsu_start while lsu_busy=1 (including in DONE) is ignored. There is no queueing.
- Address wrap: 0xFFFFFFFF + 1 gives 0x00000000 with no fault.

Optional Feature:
LSU_TIMEOUT_EN:
- Defined: an 8-bit-or-wider counter clears on ISSUE and increments each WAIT cycle. When it reaches TIMEOUT_CYCLES with no complete, go to DONE with fault 11 and lsu_load_data=0. An mmu_complete in that same cycle takes priority (no fault).
- Undefined: WAIT holds indefinitely, fault code 11 is never produced, and no counter logic is generated.

Test Plan:
- LW base=0x100, off=0x4, MMU returns 0xDEADBEEF one cycle after retrieve -> CU_address=0x104, bytesel=1111, read_or_write=0, single retrieve pulse, lsu_load_data=0xDEADBEEF, fault=00.
- LB addr=0x103, word 0x80FF0011 -> bytesel=1000, load_data=0xFFFFFF80. Repeat with LBU -> 0x00000080.
- SH base=0x200, off=0x2, rs2=0x1234ABCD -> bytesel=1100, CU_dat_in=0xABCD0000, read_or_write=1, lsu_load_data=0.
- LH addr=0x101 -> lsu_done one cycle after start, fault=01, retrieve never high. Store funct3=100 -> fault=10.
- soc_rst asserted during WAIT, then mmu_complete pulsed -> all outputs 0, lsu_done never asserted. A fresh LW then completes normally.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, MMU never completes -> fault=11 after 4 WAIT cycles. Without the macro, lsu_busy stays high for 100+ cycles.

Source files
------------

// File: rtl/lsu_ctrl.sv
// RV32I load/store sequencer between CU execute and the MMU request bus.
// Optional LSU_TIMEOUT_EN adds a WAIT-state watchdog that ends the access with fault 11.
module lsu_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        soc_clk,
  input  logic        soc_rst,
  input  logic        lsu_start,
  input  logic        lsu_is_store,
  input  logic [2:0]  lsu_funct3,
  input  logic [31:0] lsu_base,
  input  logic [31:0] lsu_offset,
  input  logic [31:0] lsu_store_data,
  output logic [31:0] lsu_load_data,
  output logic        lsu_done,
  output logic        lsu_busy,
  output logic [1:0]  lsu_fault,
  output logic [31:0] CU_address,
  output logic [3:0]  CU_bytesel,
  output logic [31:0] CU_dat_in,
  output logic        read_or_write,
  output logic        retrieve,
  input  logic [31:0] CU_dat_out,
  input  logic        mmu_complete
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        is_store_p0;
  logic [2:0]  funct3_p0;
  logic [31:0] addr_p0;
  logic [3:0]  bytesel_p0;
  logic [31:0] wdata_p0;
  logic [1:0]  fault_p1;
  logic [31:0] load_data_p1;
  logic [31:0] addr_c;
  logic        illegal_c;
  logic        misalign_c;
  logic        timeout_c;

  function automatic logic [3:0] lane_bytesel(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {24'h0, d[7:0]} << {off, 3'b000};
      2'b01:   return {16'h0, d[15:0]} << {off[1], 4'b0000};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [1:0] off);
    logic [31:0]        lane;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    lane = word >> {off, 3'b000};
    b    = lane[7:0];
    h    = lane[15:0];
    case (f3)
      3'b000:  r = b;
      3'b001:  r = h;
      3'b100:  r = {24'h0, lane[7:0]};
      3'b101:  r = {16'h0, lane[15:0]};
      default: r = lane;
    endcase
    return r;
  endfunction

  // Illegal encodings are checked before alignment, so they win when both apply.
  assign addr_c    = lsu_base + lsu_offset;
  assign illegal_c = lsu_is_store ? (lsu_funct3[2] || (lsu_funct3[1:0] == 2'b11))
                                  : ((lsu_funct3 == 3'b011) || (lsu_funct3[2:1] == 2'b11));
  assign misalign_c = ((lsu_funct3[1:0] == 2'b01) && addr_c[0]) ||
                      ((lsu_funct3[1:0] == 2'b10) && (addr_c[1:0] != 2'b00));

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef LSU_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge soc_clk) begin
    if (soc_rst)                 tmo_cnt <= '0;
    else if (state_q == S_ISSUE) tmo_cnt <= '0;
    else if (state_q == S_WAIT)  tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign timeout_c = (state_q == S_WAIT) && !mmu_complete && (tmo_cnt == TMO_LAST);
`else
  assign timeout_c = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (lsu_start) state_d = (illegal_c || misalign_c) ? S_DONE : S_ISSUE;
      S_ISSUE: state_d = mmu_complete ? S_DONE : S_WAIT;
      S_WAIT:  if (mmu_complete || timeout_c) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge soc_clk) begin
    if (soc_rst) begin
      state_q      <= S_IDLE;
      is_store_p0  <= 1'b0;
      funct3_p0    <= 3'b000;
      addr_p0      <= '0;
      bytesel_p0   <= '0;
      wdata_p0     <= '0;
      fault_p1     <= 2'b00;
      load_data_p1 <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        // p0: request capture; the MMU bus registers change only for accepted accesses
        S_IDLE: if (lsu_start) begin
          if (illegal_c) begin
            fault_p1     <= 2'b10;
            load_data_p1 <= '0;
          end else if (misalign_c) begin
            fault_p1     <= 2'b01;
            load_data_p1 <= '0;
          end else begin
            is_store_p0 <= lsu_is_store;
            funct3_p0   <= lsu_funct3;
            addr_p0     <= addr_c;
            bytesel_p0  <= lane_bytesel(lsu_funct3, addr_c[1:0]);
            wdata_p0    <= lsu_is_store ? lane_wdata(lsu_funct3, addr_c[1:0], lsu_store_data) : '0;
            fault_p1    <= 2'b00;
          end
        end
        // p1: response capture on the completing edge
        S_ISSUE, S_WAIT: begin
          if (mmu_complete) begin
            load_data_p1 <= is_store_p0 ? '0 : extend_load(CU_dat_out, funct3_p0, addr_p0[1:0]);
          end else if (timeout_c) begin
            fault_p1     <= 2'b11;
            load_data_p1 <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign retrieve      = (state_q == S_ISSUE);
  assign lsu_done      = (state_q == S_DONE);
  assign lsu_busy      = (state_q != S_IDLE);
  assign lsu_fault     = lsu_done ? fault_p1 : 2'b00;
  assign lsu_load_data = load_data_p1;
  assign CU_address    = addr_p0;
  assign CU_bytesel    = bytesel_p0;
  assign CU_dat_in     = wdata_p0;
  assign read_or_write = is_store_p0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: directed accesses push expected MMU issues and completions,
// two negedge monitors pop and compare them against the DUT.
module tb_lsu_ctrl;

`ifdef LSU_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 64;
`endif

  logic        soc_clk = 1'b0;
  logic        soc_rst = 1'b1;
  logic        lsu_start = 1'b0;
  logic        lsu_is_store = 1'b0;
  logic [2:0]  lsu_funct3 = 3'b000;
  logic [31:0] lsu_base = '0;
  logic [31:0] lsu_offset = '0;
  logic [31:0] lsu_store_data = '0;
  logic [31:0] lsu_load_data;
  logic        lsu_done;
  logic        lsu_busy;
  logic [1:0]  lsu_fault;
  logic [31:0] CU_address;
  logic [3:0]  CU_bytesel;
  logic [31:0] CU_dat_in;
  logic        read_or_write;
  logic        retrieve;
  logic [31:0] CU_dat_out = '0;
  logic        mmu_complete = 1'b0;

  lsu_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .soc_clk(soc_clk), .soc_rst(soc_rst), .lsu_start(lsu_start), .lsu_is_store(lsu_is_store),
    .lsu_funct3(lsu_funct3), .lsu_base(lsu_base), .lsu_offset(lsu_offset),
    .lsu_store_data(lsu_store_data), .lsu_load_data(lsu_load_data), .lsu_done(lsu_done),
    .lsu_busy(lsu_busy), .lsu_fault(lsu_fault), .CU_address(CU_address),
    .CU_bytesel(CU_bytesel), .CU_dat_in(CU_dat_in), .read_or_write(read_or_write),
    .retrieve(retrieve), .CU_dat_out(CU_dat_out), .mmu_complete(mmu_complete)
  );

  always #5 soc_clk = ~soc_clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  bsel;
    logic [31:0] wdat;
    logic        rw;
  } iss_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  fault;
    int          cyc;
  } dn_t;

  iss_t issue_q[$];
  dn_t  done_q[$];
  iss_t cur;
  bit   cur_valid = 0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge soc_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=none (cycle %0d)", name, cyc);
  endtask

  // MMU request monitor: every retrieve must match an expected issue; WAIT must hold the bus.
  always @(negedge soc_clk) begin
    if (retrieve) begin
      if (issue_q.size() == 0) flag("unexpected_retrieve");
      else begin
        cur = issue_q.pop_front();
        cur_valid = 1;
        chk("issue_addr", CU_address, cur.addr);
        chk("issue_bytesel", {28'h0, CU_bytesel}, {28'h0, cur.bsel});
        chk("issue_dat_in", CU_dat_in, cur.wdat);
        chk("issue_rw", {31'h0, read_or_write}, {31'h0, cur.rw});
      end
    end else if (lsu_busy && !lsu_done && cur_valid) begin
      chk("wait_addr_stable", CU_address, cur.addr);
      chk("wait_dat_stable", CU_dat_in, cur.wdat);
      chk("wait_ctl_stable", {27'h0, CU_bytesel, read_or_write}, {27'h0, cur.bsel, cur.rw});
    end
  end

  // Completion monitor.
  always @(negedge soc_clk) begin
    if (lsu_done) begin
      if (done_q.size() == 0) flag("unexpected_done");
      else begin
        dn_t d;
        d = done_q.pop_front();
        chk("load_data", lsu_load_data, d.data);
        chk("fault", {30'h0, lsu_fault}, {30'h0, d.fault});
        chk("done_cycle", 32'(cyc), 32'(d.cyc));
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_load_data"}, lsu_load_data, 32'h0);
    chk({tag, "_done"}, {31'h0, lsu_done}, 32'h0);
    chk({tag, "_busy"}, {31'h0, lsu_busy}, 32'h0);
    chk({tag, "_fault"}, {30'h0, lsu_fault}, 32'h0);
    chk({tag, "_addr"}, CU_address, 32'h0);
    chk({tag, "_bytesel"}, {28'h0, CU_bytesel}, 32'h0);
    chk({tag, "_dat_in"}, CU_dat_in, 32'h0);
    chk({tag, "_rw"}, {31'h0, read_or_write}, 32'h0);
    chk({tag, "_retrieve"}, {31'h0, retrieve}, 32'h0);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (lsu_busy && k < 50) begin
      @(negedge soc_clk);
      k++;
    end
    chk({tag, "_returns_idle"}, {31'h0, lsu_busy}, 32'h0);
  endtask

  // delay = cycles after the ISSUE cycle before mmu_complete (0 = complete during ISSUE).
  task automatic do_access(input string tag, input logic st, input logic [2:0] f3,
                           input logic [31:0] base, input logic [31:0] off,
                           input logic [31:0] sdata, input logic [31:0] word, input int delay,
                           input logic [1:0] fault, input logic [31:0] addr,
                           input logic [3:0] bsel, input logic [31:0] wdat,
                           input logic [31:0] ldata, input bit poke);
    iss_t is;
    dn_t  d;
    @(negedge soc_clk);
    lsu_is_store   = st;
    lsu_funct3     = f3;
    lsu_base       = base;
    lsu_offset     = off;
    lsu_store_data = sdata;
    lsu_start      = 1'b1;
    d.data  = ldata;
    d.fault = fault;
    d.cyc   = cyc + 1 + ((fault == 2'b00) ? 1 + delay : 0);
    done_q.push_back(d);
    if (fault == 2'b00) begin
      is.addr = addr;
      is.bsel = bsel;
      is.wdat = wdat;
      is.rw   = st;
      issue_q.push_back(is);
    end
    @(negedge soc_clk);
    lsu_start      = 1'b0;
    lsu_is_store   = ~st;
    lsu_funct3     = 3'b010;
    lsu_base       = 32'h0;
    lsu_offset     = 32'h0;
    lsu_store_data = 32'h5A5A5A5A;
    if (fault == 2'b00) begin
      for (int i = 0; i < delay; i++) begin
        lsu_start = poke;
        @(negedge soc_clk);
      end
      lsu_start    = 1'b0;
      mmu_complete = 1'b1;
      CU_dat_out   = word;
      @(negedge soc_clk);
      mmu_complete = 1'b0;
      CU_dat_out   = 32'hBAD0BAD0;
    end
    wait_idle(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    iss_t is;
    dn_t  d;
    soc_rst = 1'b1;
    repeat (3) @(negedge soc_clk);
    chk_zero("in_reset");
    soc_rst = 1'b0;
    @(negedge soc_clk);
    chk_zero("after_reset");

    //        tag     st    f3      base          off           sdata         word          dly flt    addr          bsel     wdat          ldata         poke
    do_access("lw",   1'b0, 3'b010, 32'h00000100, 32'h00000004, 32'h0,        32'hDEADBEEF, 1, 2'b00, 32'h00000104, 4'b1111, 32'h0,        32'hDEADBEEF, 0);
    do_access("lb",   1'b0, 3'b000, 32'h00000100, 32'h00000003, 32'h0,        32'h80FF0011, 1, 2'b00, 32'h00000103, 4'b1000, 32'h0,        32'hFFFFFF80, 0);
    do_access("lbu",  1'b0, 3'b100, 32'h00000100, 32'h00000003, 32'h0,        32'h80FF0011, 1, 2'b00, 32'h00000103, 4'b1000, 32'h0,        32'h00000080, 0);
    do_access("lb2",  1'b0, 3'b000, 32'h00000100, 32'h00000002, 32'h0,        32'h80FF0011, 0, 2'b00, 32'h00000102, 4'b0100, 32'h0,        32'hFFFFFFFF, 0);
    do_access("sh",   1'b1, 3'b001, 32'h00000200, 32'h00000002, 32'h1234ABCD, 32'hFFFFFFFF, 0, 2'b00, 32'h00000202, 4'b1100, 32'hABCD0000, 32'h0,        0);
    do_access("lh_mis", 1'b0, 3'b001, 32'h00000100, 32'h00000001, 32'h0,      32'h0,        0, 2'b01, 32'h0,        4'b0000, 32'h0,        32'h0,        0);
    do_access("st_ill", 1'b1, 3'b100, 32'h00000200, 32'h00000000, 32'h1,      32'h0,        0, 2'b10, 32'h0,        4'b0000, 32'h0,        32'h0,        0);
    do_access("ld_ill", 1'b0, 3'b011, 32'h00000100, 32'h00000001, 32'h0,      32'h0,        0, 2'b10, 32'h0,        4'b0000, 32'h0,        32'h0,        0);
    do_access("lh",   1'b0, 3'b001, 32'h00000100, 32'h00000002, 32'h0,        32'h80017FFF, 2, 2'b00, 32'h00000102, 4'b1100, 32'h0,        32'hFFFF8001, 0);
    do_access("lhu",  1'b0, 3'b101, 32'h00000100, 32'h00000002, 32'h0,        32'h80017FFF, 1, 2'b00, 32'h00000102, 4'b1100, 32'h0,        32'h00008001, 1);
    do_access("lw_mis", 1'b0, 3'b010, 32'h00000100, 32'h00000002, 32'h0,      32'h0,        0, 2'b01, 32'h0,        4'b0000, 32'h0,        32'h0,        0);
    do_access("wrap", 1'b0, 3'b010, 32'hFFFFFFFF, 32'h00000001, 32'h0,        32'h12345678, 1, 2'b00, 32'h00000000, 4'b1111, 32'h0,        32'h12345678, 0);
    do_access("sb",   1'b1, 3'b000, 32'h00000300, 32'h00000001, 32'hCAFE12A5, 32'h11111111, 1, 2'b00, 32'h00000301, 4'b0010, 32'h0000A500, 32'h0,        0);
    do_access("sw",   1'b1, 3'b010, 32'h00000400, 32'hFFFFFFFC, 32'h11223344, 32'h99999999, 3, 2'b00, 32'h000003FC, 4'b1111, 32'h11223344, 32'h0,        1);
    do_access("lh_neg", 1'b0, 3'b001, 32'h00000010, 32'hFFFFFFF2, 32'h0,      32'h7FFE0000, 1, 2'b00, 32'h00000002, 4'b1100, 32'h0,        32'h00007FFE, 0);
    do_access("sw_mis", 1'b1, 3'b010, 32'h00000401, 32'h00000000, 32'h1,      32'h0,        0, 2'b01, 32'h0,        4'b0000, 32'h0,        32'h0,        0);

    // Reset while waiting on the MMU, then a late completion in IDLE.
    @(negedge soc_clk);
    lsu_is_store = 1'b0;
    lsu_funct3   = 3'b010;
    lsu_base     = 32'h00000500;
    lsu_offset   = 32'h0;
    lsu_start    = 1'b1;
    is.addr = 32'h00000500; is.bsel = 4'b1111; is.wdat = 32'h0; is.rw = 1'b0;
    issue_q.push_back(is);
    @(negedge soc_clk);
    lsu_start = 1'b0;
    @(negedge soc_clk);
    soc_rst = 1'b1;
    @(negedge soc_clk);
    chk_zero("abort");
    soc_rst = 1'b0;
    @(negedge soc_clk);
    mmu_complete = 1'b1;
    CU_dat_out   = 32'hFEEDFACE;
    @(negedge soc_clk);
    mmu_complete = 1'b0;
    repeat (3) @(negedge soc_clk);
    chk_zero("late_complete");

    do_access("lw_fresh", 1'b0, 3'b010, 32'h00000008, 32'h0, 32'h0, 32'hA5A5A5A5, 1, 2'b00,
              32'h00000008, 4'b1111, 32'h0, 32'hA5A5A5A5, 0);

    // MMU that never answers.
    @(negedge soc_clk);
    lsu_is_store = 1'b0;
    lsu_funct3   = 3'b010;
    lsu_base     = 32'h00000600;
    lsu_offset   = 32'h0;
    lsu_start    = 1'b1;
    is.addr = 32'h00000600; is.bsel = 4'b1111; is.wdat = 32'h0; is.rw = 1'b0;
    issue_q.push_back(is);
`ifdef LSU_TIMEOUT_EN
    d.data = 32'h0; d.fault = 2'b11; d.cyc = cyc + 2 + TMO;
    done_q.push_back(d);
    @(negedge soc_clk);
    lsu_start = 1'b0;
    wait_idle("timeout");
`else
    @(negedge soc_clk);
    lsu_start = 1'b0;
    repeat (120) @(negedge soc_clk);
    chk("hang_busy", {31'h0, lsu_busy}, 32'h1);
    soc_rst = 1'b1;
    @(negedge soc_clk);
    soc_rst = 1'b0;
    @(negedge soc_clk);
    chk_zero("hang_abort");
`endif

    repeat (2) @(negedge soc_clk);
    chk("issue_q_empty", 32'(issue_q.size()), 32'h0);
    chk("done_q_empty", 32'(done_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
